// File: rtl/cpu_defs.sv
// Shared CPU definitions: hazard-unit handshake type and access size encoding.
package cpu_defs;

    typedef struct packed {
        logic busy;
        logic ok;
    } busy_ok_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dmem_sram_ctrl.sv
// MEM-stage data memory controller bridging the pipeline to an sram-like bus,
// with one transaction outstanding and cancellation draining.
module dmem_sram_ctrl
    import cpu_defs::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_req,
    input  logic          m_wr,
    input  logic [1:0]    m_size,
    input  logic [AW-1:0] m_addr,
    input  logic [DW-1:0] m_wdata,
    input  logic          m_hold,
    input  logic          m_flush,
    output busy_ok_t      idmem,
    output logic [DW-1:0] m_rdata,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          cancel_q, cancel_d;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          issue, busy, ok, capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            if (issue) begin
                wr_q    <= m_wr;
                size_q  <= m_size;
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
            end
            if (capture)
                rdata_q <= data_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cancel_d   = cancel_q;
        issue      = 1'b0;
        busy       = 1'b0;
        ok         = 1'b0;
        capture    = 1'b0;
        data_req   = 1'b0;
        data_wr    = wr_q;
        data_size  = size_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                // Issue cycle drives the live m_* fields; later cycles use the latched copy.
                if (m_req && !m_flush && !rst) begin
                    issue      = 1'b1;
                    data_req   = 1'b1;
                    data_wr    = m_wr;
                    data_size  = m_size;
                    data_addr  = m_addr;
                    data_wdata = m_wdata;
                    busy       = !(data_addr_ok && data_data_ok);
                    if (data_addr_ok && data_data_ok) begin
                        ok      = 1'b1;
                        capture = !m_wr;
                        state_d = DONE;
                    end else if (data_addr_ok) begin
                        state_d = DATA;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                data_req = 1'b1;
                busy     = 1'b1;
                if (data_addr_ok) begin
                    if (cancel_q || m_flush)
                        state_d = data_data_ok ? IDLE : DRAIN;
                    else if (data_data_ok) begin
                        ok      = 1'b1;
                        capture = !wr_q;
                        state_d = DONE;
                    end else
                        state_d = DATA;
                end else if (m_flush) begin
                    cancel_d = 1'b1;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (m_flush)
                    state_d = data_data_ok ? IDLE : DRAIN;
                else if (data_data_ok) begin
                    ok      = 1'b1;
                    capture = !wr_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (m_flush || !m_hold)
                    state_d = IDLE;
            end
            DRAIN: begin
                if (data_data_ok)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        idmem   = '{busy: busy, ok: ok};
        m_rdata = capture ? data_rdata : rdata_q;
    end

endmodule
